// File: rtl/lfo_cordic_seq.sv
// rtl/lfo_cordic_seq.sv - two-channel LFO sequencer sharing one cordic (optional macro LFO_CORDIC_SEQ_PIPE_EN)

// Combinational first-quadrant cordic: angle 0..402 spans 0..90 degrees (1/256 rad per code),
// outputs unsigned 8-bit magnitudes with full scale 255.
module cordic (
    input  logic [8:0] angle_i,
    output logic [7:0] sin_o,
    output logic [7:0] cos_o
);

    localparam int ITER = 12;

    // atan(2^-i) scaled by 2^14 rad, matching the angle code shifted left by 6
    localparam logic signed [19:0] ATAN [0:ITER-1] = '{
        20'sd12868, 20'sd7596, 20'sd4014, 20'sd2037,
        20'sd1023,  20'sd512,  20'sd256,  20'sd128,
        20'sd64,    20'sd32,   20'sd16,   20'sd8
    };

    // 255 * 256 pre-scaled by the cordic gain so the final x/y land on 8.8 fixed point
    localparam logic signed [19:0] X_INIT = 20'sd39642;

    logic signed [19:0] x [0:ITER];
    logic signed [19:0] y [0:ITER];
    logic signed [19:0] z [0:ITER-1];

    assign x[0] = X_INIT;
    assign y[0] = '0;
    assign z[0] = $signed({5'b0, angle_i, 6'b0});

    // Unrolled rotation-mode micro-rotations, one stage per iteration
    for (genvar i = 0; i < ITER; i++) begin : g_stage
        assign x[i+1] = z[i][19] ? x[i] + (y[i] >>> i) : x[i] - (y[i] >>> i);
        assign y[i+1] = z[i][19] ? y[i] - (x[i] >>> i) : y[i] + (x[i] >>> i);
        if (i < ITER - 1) begin : g_z
            assign z[i+1] = z[i][19] ? z[i] + ATAN[i] : z[i] - ATAN[i];
        end
    end

    // Round the 8.8 result to an integer and clamp into 0..255
    function automatic logic [7:0] sat8(input logic signed [19:0] v);
        logic signed [19:0] t;
        t = v + 20'sd128;
        if (t < 0)
            return 8'd0;
        else if (t > 20'sd65535)
            return 8'd255;
        else
            return 8'(t >>> 8);
    endfunction

    assign sin_o = sat8(y[ITER]);
    assign cos_o = sat8(x[ITER]);

endmodule

module lfo_cordic_seq #(
    parameter int PHASE_W = 20,
    parameter int QUARTER = 402
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                tick_i,
    input  logic [PHASE_W-1:0]  step0_i,
    input  logic [PHASE_W-1:0]  step1_i,
    input  logic [1:0]          req_i,
    output logic [1:0]          ack_o,
    output logic signed [8:0]   sin_o,
    output logic signed [8:0]   cos_o,
    output logic                busy_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd3;
`ifdef LFO_CORDIC_SEQ_PIPE_EN
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_LOAD = S_WAIT;
    localparam logic [1:0] S_POST_CALC = S_WAIT;
`else
    localparam logic [1:0] S_LOAD = S_CALC;
    localparam logic [1:0] S_POST_CALC = S_DONE;
`endif

    logic [PHASE_W-1:0] ph0;
    logic [PHASE_W-1:0] ph1;
    logic [1:0]         state;
    logic               prio;
    logic               ch_r;
    logic [1:0]         q_r;
    logic [8:0]         angle_r;

    logic               grant_any;
    logic               grant_ch;
    logic [1:0]         q_nxt;
    logic [8:0]         f9_nxt;
    logic [8:0]         angle_nxt;

    logic [7:0]         cs;
    logic [7:0]         cc;
    logic [7:0]         s_src;
    logic [7:0]         c_src;
    logic signed [8:0]  sin_nxt;
    logic signed [8:0]  cos_nxt;

    cordic u_cordic (
        .angle_i (angle_r),
        .sin_o   (cs),
        .cos_o   (cc)
    );

    // Free-running per-channel phase accumulators, advanced on each sample tick
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ph0 <= '0;
            ph1 <= '0;
        end else if (tick_i) begin
            ph0 <= ph0 + step0_i;
            ph1 <= ph1 + step1_i;
        end
    end

    // Round-robin choice between requesters; a lone requester always wins
    always_comb begin
        grant_any = |req_i;
        grant_ch  = 1'b0;
        case (req_i)
            2'b01:   grant_ch = 1'b0;
            2'b10:   grant_ch = 1'b1;
            2'b11:   grant_ch = prio;
            default: grant_ch = 1'b0;
        endcase
    end

    // Fold the granted (pre-tick) phase into quadrant plus first-quadrant cordic angle
    always_comb begin
        q_nxt     = grant_ch ? ph1[PHASE_W-1 -: 2] : ph0[PHASE_W-1 -: 2];
        f9_nxt    = grant_ch ? ph1[PHASE_W-3 -: 9] : ph0[PHASE_W-3 -: 9];
        angle_nxt = 9'((18'(f9_nxt) * 18'(QUARTER)) >> 9);
    end

`ifdef LFO_CORDIC_SEQ_PIPE_EN
    logic [7:0] s_r;
    logic [7:0] c_r;

    // Capture the raw cordic result so the output correction starts from a register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s_r <= '0;
            c_r <= '0;
        end else if (state == S_CALC) begin
            s_r <= cs;
            c_r <= cc;
        end
    end

    assign s_src = s_r;
    assign c_src = c_r;
`else
    assign s_src = cs;
    assign c_src = cc;
`endif

    // Map the first-quadrant magnitudes back to the full circle using the latched quadrant
    always_comb begin
        sin_nxt = '0;
        cos_nxt = '0;
        case (q_r)
            2'd0: begin
                sin_nxt =  $signed({1'b0, s_src});
                cos_nxt =  $signed({1'b0, c_src});
            end
            2'd1: begin
                sin_nxt =  $signed({1'b0, c_src});
                cos_nxt = -$signed({1'b0, s_src});
            end
            2'd2: begin
                sin_nxt = -$signed({1'b0, s_src});
                cos_nxt = -$signed({1'b0, c_src});
            end
            default: begin
                sin_nxt = -$signed({1'b0, c_src});
                cos_nxt =  $signed({1'b0, s_src});
            end
        endcase
    end

    // Sequencer: grant in IDLE, evaluate, optionally wait on the pipe register, then ack
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= S_IDLE;
            prio    <= 1'b0;
            ch_r    <= 1'b0;
            q_r     <= '0;
            angle_r <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_any) begin
                        ch_r    <= grant_ch;
                        q_r     <= q_nxt;
                        angle_r <= angle_nxt;
                        prio    <= ~grant_ch;
                        state   <= S_CALC;
                    end
                end
                S_CALC: state <= S_POST_CALC;
`ifdef LFO_CORDIC_SEQ_PIPE_EN
                S_WAIT: state <= S_DONE;
`endif
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Result registers hold the last served value until the next result lands
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sin_o <= '0;
            cos_o <= '0;
        end else if (state == S_LOAD) begin
            sin_o <= sin_nxt;
            cos_o <= cos_nxt;
        end
    end

    assign ack_o  = (state == S_DONE) ? (ch_r ? 2'b10 : 2'b01) : 2'b00;
    assign busy_o = (state != S_IDLE);

endmodule

// File: tb/tb_lfo_cordic_seq.sv
// tb/tb_lfo_cordic_seq.sv - directed self-checking bench for lfo_cordic_seq
module tb_lfo_cordic_seq;

`ifdef LFO_CORDIC_SEQ_PIPE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif
    localparam int SPACING = LAT + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              tick;
    logic [19:0]       step0;
    logic [19:0]       step1;
    logic [1:0]        req;
    logic [1:0]        ack;
    logic signed [8:0] sin_v;
    logic signed [8:0] cos_v;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lfo_cordic_seq #(.PHASE_W(20), .QUARTER(402)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .tick_i  (tick),
        .step0_i (step0),
        .step1_i (step1),
        .req_i   (req),
        .ack_o   (ack),
        .sin_o   (sin_v),
        .cos_o   (cos_v),
        .busy_o  (busy)
    );

    function automatic bit far(input int a, input int b);
        return (a > b + 4) || (a < b - 4);
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0;
        tick  = 1'b0;
        req   = 2'b00;
        step0 = '0;
        step1 = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_tick(input int n);
        for (int k = 0; k < n; k++) begin
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    endtask

    task automatic do_req(input logic [1:0] r, output int lat, output int s, output int c,
                          output logic [1:0] a);
        lat = -1;
        s   = 0;
        c   = 0;
        a   = 2'b00;
        req = r;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (ack !== 2'b00) begin
                lat = k;
                a   = ack;
                s   = sin_v;
                c   = cos_v;
                break;
            end
        end
        req = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++; if (ack !== 2'b00) begin n_fail++; $display("FAIL reset_ack got=%b want=00", ack); end
        n_checks++; if (sin_v !== 9'sd0) begin n_fail++; $display("FAIL reset_sin got=%0d want=0", sin_v); end
        n_checks++; if (cos_v !== 9'sd0) begin n_fail++; $display("FAIL reset_cos got=%0d want=0", cos_v); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
    endtask

    task automatic test_first();
        apply_reset();
        req = 2'b01;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL first_busy cyc=%0d got=%b want=1", k, busy); end
            if (k < LAT) begin
                n_checks++; if (ack !== 2'b00) begin n_fail++; $display("FAIL first_early_ack cyc=%0d got=%b want=00", k, ack); end
            end else begin
                n_checks++; if (ack !== 2'b01) begin n_fail++; $display("FAIL first_ack got=%b want=01", ack); end
                n_checks++; if (far(sin_v, 0)) begin n_fail++; $display("FAIL first_sin got=%0d want=0", sin_v); end
                n_checks++; if (far(cos_v, 255)) begin n_fail++; $display("FAIL first_cos got=%0d want=255", cos_v); end
            end
        end
        req = 2'b00;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL first_busy_end got=%b want=0", busy); end
        n_checks++; if (ack !== 2'b00) begin n_fail++; $display("FAIL first_ack_pulse got=%b want=00", ack); end
    endtask

    task automatic test_quadrants();
        int exp_s [0:4] = '{255, 0, -255, 0, 0};
        int exp_c [0:4] = '{0, -255, 0, 255, 255};
        int lat, s, c;
        logic [1:0] a;
        apply_reset();
        step0 = 20'h40000;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                step0 = 20'h0;
                do_tick(3);
            end else begin
                do_tick(1);
            end
            do_req(2'b01, lat, s, c, a);
            n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL quad%0d_latency got=%0d want=%0d", i, lat, LAT); end
            n_checks++; if (a !== 2'b01) begin n_fail++; $display("FAIL quad%0d_ack got=%b want=01", i, a); end
            n_checks++; if (far(s, exp_s[i])) begin n_fail++; $display("FAIL quad%0d_sin got=%0d want=%0d", i, s, exp_s[i]); end
            n_checks++; if (far(c, exp_c[i])) begin n_fail++; $display("FAIL quad%0d_cos got=%0d want=%0d", i, c, exp_c[i]); end
        end
    endtask

    task automatic test_diag();
        int lat, s, c;
        logic [1:0] a;
        apply_reset();
        step0 = 20'h20000;
        step1 = 20'hA0000;
        do_tick(1);
        do_req(2'b01, lat, s, c, a);
        n_checks++; if (dut.angle_r !== 9'd201) begin n_fail++; $display("FAIL diag_angle got=%0d want=201", dut.angle_r); end
        n_checks++; if (a !== 2'b01) begin n_fail++; $display("FAIL diag0_ack got=%b want=01", a); end
        n_checks++; if (far(s, 180)) begin n_fail++; $display("FAIL diag0_sin got=%0d want=180", s); end
        n_checks++; if (far(c, 180)) begin n_fail++; $display("FAIL diag0_cos got=%0d want=180", c); end
        do_req(2'b10, lat, s, c, a);
        n_checks++; if (a !== 2'b10) begin n_fail++; $display("FAIL diag1_ack got=%b want=10", a); end
        n_checks++; if (far(s, -180)) begin n_fail++; $display("FAIL diag1_sin got=%0d want=-180", s); end
        n_checks++; if (far(c, -180)) begin n_fail++; $display("FAIL diag1_cos got=%0d want=-180", c); end
    endtask

    task automatic test_back_to_back();
        int cyc [0:3];
        logic [1:0] chn [0:3];
        logic [1:0] want;
        int n = 0;
        apply_reset();
        req = 2'b11;
        for (int k = 1; k <= 40 && n < 4; k++) begin
            @(negedge clk);
            if (ack !== 2'b00) begin
                cyc[n] = k;
                chn[n] = ack;
                n++;
            end
        end
        req = 2'b00;
        repeat (LAT + 2) @(negedge clk);
        n_checks++; if (n != 4) begin n_fail++; $display("FAIL b2b_count got=%0d want=4", n); end
        if (n == 4) begin
            n_checks++; if (cyc[0] != LAT) begin n_fail++; $display("FAIL b2b_first got=%0d want=%0d", cyc[0], LAT); end
            for (int i = 0; i < 4; i++) begin
                want = (i % 2 == 0) ? 2'b01 : 2'b10;
                n_checks++; if (chn[i] !== want) begin n_fail++; $display("FAIL b2b_ch%0d got=%b want=%b", i, chn[i], want); end
                if (i > 0) begin
                    n_checks++; if (cyc[i] - cyc[i-1] != SPACING) begin n_fail++; $display("FAIL b2b_gap%0d got=%0d want=%0d", i, cyc[i] - cyc[i-1], SPACING); end
                end
            end
        end
    endtask

    task automatic test_tick_grant();
        int lat, s, c;
        logic [1:0] a;
        bit seen = 0;
        apply_reset();
        step0 = 20'h40000;
        req   = 2'b01;
        tick  = 1'b1;
        @(negedge clk);
        tick  = 1'b0;
        for (int k = 2; k <= 20; k++) begin
            @(negedge clk);
            if (ack !== 2'b00) begin
                seen = 1;
                s = sin_v;
                c = cos_v;
                break;
            end
        end
        req = 2'b00;
        @(negedge clk);
        n_checks++; if (!seen) begin n_fail++; $display("FAIL tickgrant_ack got=none want=01"); end
        n_checks++; if (far(c, 255)) begin n_fail++; $display("FAIL tickgrant_cos got=%0d want=255", c); end
        n_checks++; if (far(s, 0)) begin n_fail++; $display("FAIL tickgrant_sin got=%0d want=0", s); end
        do_req(2'b01, lat, s, c, a);
        n_checks++; if (far(s, 255)) begin n_fail++; $display("FAIL tickgrant_next_sin got=%0d want=255", s); end
        n_checks++; if (far(c, 0)) begin n_fail++; $display("FAIL tickgrant_next_cos got=%0d want=0", c); end
    endtask

    task automatic test_reset_mid();
        int lat, s, c;
        int stray = 0;
        logic [1:0] a;
        apply_reset();
        do_req(2'b01, lat, s, c, a);
        req = 2'b01;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++; if (ack !== 2'b00) begin n_fail++; $display("FAIL midrst_ack got=%b want=00", ack); end
        n_checks++; if (sin_v !== 9'sd0) begin n_fail++; $display("FAIL midrst_sin got=%0d want=0", sin_v); end
        n_checks++; if (cos_v !== 9'sd0) begin n_fail++; $display("FAIL midrst_cos got=%0d want=0", cos_v); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b want=0", busy); end
        @(negedge clk);
        req = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (ack !== 2'b00) stray++;
        end
        n_checks++; if (stray != 0) begin n_fail++; $display("FAIL midrst_stray_ack got=%0d want=0", stray); end
        do_req(2'b11, lat, s, c, a);
        n_checks++; if (a !== 2'b01) begin n_fail++; $display("FAIL midrst_prio got=%b want=01", a); end
        n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL midrst_latency got=%0d want=%0d", lat, LAT); end
        n_checks++; if (far(c, 255)) begin n_fail++; $display("FAIL midrst_cos_after got=%0d want=255", c); end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_first();
        test_quadrants();
        test_diag();
        test_back_to_back();
        test_tick_grant();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
